vga_text_buffer: RTL and testbench
==================================

// Module: vga_text_buffer
// PURPOSE
//  Character sink for the VGA text path. Accepts bytes on the data/write_en interface
//  driven by the top-level UART bridge. Interprets printable ASCII and control codes
//  into a ROWS x COLS character RAM, with cursor tracking and hardware scroll.
//  Provides a 1-cycle read port to the pixel/font pipeline.
// PARAMETERS
//  COLS      80   characters per row (640 px / 8 px glyph)
//  ROWS      30   rows on screen (480 px / 16 px glyph)
//  BLANK     8'h20  fill code used by init, scroll-clear and backspace
// PORTS
//  clk       in   1   system clock (100 MHz); all logic on posedge
//  reset     in   1   synchronous, active-high
//  data      in   8   character byte; sampled on the write_en rising edge
//  write_en  in   1   write strobe; level may span many clk cycles (baud-width pulse)
//  rd_col    in   7   display column to read, 0..COLS-1
//  rd_row    in   5   display row to read, 0..ROWS-1 (0 = top of screen)
//  rd_char   out  8   character at (rd_row, rd_col), registered, 1-cycle latency
//  cur_col   out  7   cursor column
//  cur_row   out  5   cursor display row
//  busy      out  1   high while in INIT or CLR_ROW
//  overflow  out  1   sticky: accepted strobe was dropped; cleared only by reset
// BEHAVIOUR
//  Reset values
//  - cur_col=0, cur_row=0, top=0, busy=1, overflow=0, rd_char=BLANK, pend=0.
//  - FSM enters INIT.
//  Strobe detection
//  - Strobe = write_en & ~write_en_q (rising edge); one character per edge.
//  - Held-high write_en never repeats.
//  Pending register (1 deep)
//  - On strobe, data is latched into pend_byte and pend=1.
//  - Strobe while pend=1: byte dropped, overflow<=1.
//  FSM states
//  - INIT: writes BLANK to every physical address, one per cycle (ROWS*COLS cycles).
//    Goes to IDLE after last address.
//  - IDLE: if pend, consume pend_byte next cycle (pend<=0) and act on it:
//    - 0x20..0x7E: RAM[phys(cur_row),cur_col]<=byte; cur_col++.
//      If cur_col was COLS-1: cur_col<=0, do NEWLINE.
//    - 0x0D (CR): cur_col<=0.
//    - 0x0A (LF): do NEWLINE (col unchanged).
//    - 0x08 (BS): if cur_col>0, cur_col--, RAM at new position <=BLANK.
//      At col 0: no-op, no wrap to previous row.
//    - Any other code: ignored; no state change.
//  - NEWLINE:
//    - If cur_row<ROWS-1: cur_row++.
//    - Else (scroll): top<=(top+1) mod ROWS, cur_row stays ROWS-1, go to CLR_ROW.
//  - CLR_ROW: writes BLANK to the COLS cells of the new bottom physical row
//    (old top), one per cycle, then returns to IDLE.
//  Pending during INIT/CLR_ROW
//  - Bytes arriving while busy sit in pend until IDLE.
//  Address mapping and read port
//  - phys(r) = (r+top) mod ROWS; explicit compare/subtract, no power-of-2 assumption.
//  - RAM address = phys*COLS + col; 12 bits for defaults.
//  - rd_char <= RAM[phys(rd_row)*COLS+rd_col] every cycle.
//  - Same-cycle write and read of one address returns OLD data (read-first).
//  - Out-of-range rd_col/rd_row return BLANK.
//  Mid-operation reset
//  - Reset mid-INIT/CLR_ROW restarts INIT.
//  - pend discarded, overflow cleared.
// TESTING
//  1. Reset; count cycles busy=1 -> exactly 2400; all 2400 reads return 8'h20.
//  2. Send 'A','B' (0x41,0x42) after INIT -> (0,0)=0x41, (0,1)=0x42, cur_col=2.
//  3. Send 80x 0x58 -> row 0 full of 0x58, cur_col=0, cur_row=1 (auto-wrap).
//  4. Send 30x LF then 'Z' -> scroll once; busy high 80 cycles.
//     Display row 29 holds 'Z' at col 0; display row 0 = old row 1.
//  5. 'Q', BS, BS -> (0,0)=0x20, cur_col=0; second BS no-op.
//     Send 0x07 -> nothing changes.
//  6. Two strobes 1 cycle apart during CLR_ROW -> first kept, second dropped;
//     overflow=1 until reset. write_en held 1000 cycles -> one char written.

Source files
------------

// File: rtl/vga_text_buffer_if.sv
// vga_text_buffer_if
//   Bundle between the text buffer and its neighbours.
//   master : UART bridge and pixel pipeline side
//            drives data, write_en (byte strobe) and rd_row, rd_col (display read address)
//   slave  : the text buffer
//            returns rd_char, cur_col, cur_row, busy and overflow
interface vga_text_buffer_if;
   logic [7:0] data;
   logic       write_en;
   logic [6:0] rd_col;
   logic [4:0] rd_row;
   logic [7:0] rd_char;
   logic [6:0] cur_col;
   logic [4:0] cur_row;
   logic       busy;
   logic       overflow;

   modport master (
      output data, write_en, rd_col, rd_row,
      input  rd_char, cur_col, cur_row, busy, overflow
   );

   modport slave (
      input  data, write_en, rd_col, rd_row,
      output rd_char, cur_col, cur_row, busy, overflow
   );
endinterface

// File: rtl/vga_text_buffer.sv
// vga_text_buffer
//   Character sink for the VGA text path. Bytes from the UART bridge are
//   interpreted as printable ASCII or control codes (CR, LF, BS) and written
//   into a ROWS x COLS character RAM. The RAM tracks a cursor and scrolls in
//   hardware by rotating a top-row pointer. A registered read port with
//   1-cycle latency serves the font pipeline.
// Ports
//   clk    : system clock; all logic runs on posedge
//   reset  : synchronous, active high
//   bus    : slave side of vga_text_buffer_if
//            data, write_en     -> byte in; one byte per write_en rising edge
//            rd_row, rd_col     -> display read address
//            rd_char            <- character at the read address, registered
//            cur_row, cur_col   <- cursor position
//            busy               <- high while in INIT or CLR_ROW
//            overflow           <- sticky flag: an incoming byte was dropped
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_INIT    | blank every RAM cell, one per cycle, from the last cell down to 0
// S_IDLE    | consume the pending byte, if any, and act on it
// S_CLR_ROW | blank the COLS cells of the physical row just rotated to the bottom
module vga_text_buffer #(
   parameter int         COLS  = 80,
   parameter int         ROWS  = 30,
   parameter logic [7:0] BLANK = 8'h20
) (
   input logic              clk,
   input logic              reset,
   vga_text_buffer_if.slave bus
);
   localparam int CELLS = ROWS * COLS;
   localparam int AW    = $clog2(CELLS);

   localparam logic [6:0]    COL_LAST   = 7'(COLS - 1);
   localparam logic [4:0]    ROW_LAST   = 5'(ROWS - 1);
   localparam logic [AW-1:0] CELL_LAST  = AW'(CELLS - 1);
   localparam logic [AW-1:0] COL_LAST_A = AW'(COLS - 1);

   localparam logic [7:0] CH_BS = 8'h08;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_CR = 8'h0D;

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_CLR_ROW} state_t;

   state_t        state;
   logic [7:0]    mem [CELLS];
   logic [AW-1:0] cnt;
   logic [AW-1:0] clr_base;
   logic [6:0]    cur_col;
   logic [4:0]    cur_row;
   logic [4:0]    top;
   logic          busy_q;
   logic          overflow_q;
   logic          write_en_q;
   logic          pend;
   logic [7:0]    pend_byte;
   logic [7:0]    rd_char_q;

   logic          strobe;
   logic          consume;
   logic          printable;
   logic          nl_req;
   logic          rd_valid;
   logic [AW-1:0] cur_addr;
   logic [AW-1:0] bs_addr;
   logic [AW-1:0] rd_addr;

   // Display row to physical row. ROWS need not be a power of two, so the
   // wrap is an explicit compare and subtract.
   function automatic logic [4:0] phys_row(input logic [4:0] r, input logic [4:0] t);
      logic [5:0] s;
      s = {1'b0, r} + {1'b0, t};
      if (s >= 6'(ROWS)) s = s - 6'(ROWS);
      return 5'(s);
   endfunction

   function automatic logic [AW-1:0] cell_addr(input logic [4:0] p, input logic [6:0] c);
      return AW'(p) * AW'(COLS) + AW'(c);
   endfunction

   assign strobe    = bus.write_en & ~write_en_q;
   assign consume   = (state == S_IDLE) && pend;
   assign printable = (pend_byte >= 8'h20) && (pend_byte <= 8'h7E);
   assign nl_req    = consume && ((printable && (cur_col == COL_LAST)) || (pend_byte == CH_LF));
   assign cur_addr  = cell_addr(phys_row(cur_row, top), cur_col);
   assign bs_addr   = cell_addr(phys_row(cur_row, top), cur_col - 7'd1);
   assign rd_valid  = (bus.rd_col <= COL_LAST) && (bus.rd_row <= ROW_LAST);
   assign rd_addr   = cell_addr(phys_row(bus.rd_row, top), bus.rd_col);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_INIT;
         cnt        <= CELL_LAST;
         clr_base   <= '0;
         cur_col    <= '0;
         cur_row    <= '0;
         top        <= '0;
         busy_q     <= 1'b1;
         overflow_q <= 1'b0;
         write_en_q <= 1'b0;
         pend       <= 1'b0;
         pend_byte  <= BLANK;
      end else begin
         write_en_q <= bus.write_en;

         // One-deep holding register; a second byte before the first is
         // consumed is lost and flagged.
         if (strobe) begin
            if (pend) begin
               overflow_q <= 1'b1;
            end else begin
               pend      <= 1'b1;
               pend_byte <= bus.data;
            end
         end

         case (state)
            S_INIT: begin
               mem[cnt] <= BLANK;
               if (cnt == '0) begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            S_CLR_ROW: begin
               mem[clr_base + cnt] <= BLANK;
               if (cnt == '0) begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            S_IDLE: begin
               if (pend) begin
                  pend <= 1'b0;
                  if (printable) begin
                     mem[cur_addr] <= pend_byte;
                     if (cur_col == COL_LAST) cur_col <= '0;
                     else                     cur_col <= cur_col + 7'd1;
                  end else if (pend_byte == CH_CR) begin
                     cur_col <= '0;
                  end else if (pend_byte == CH_BS) begin
                     if (cur_col != '0) begin
                        cur_col      <= cur_col - 7'd1;
                        mem[bs_addr] <= BLANK;
                     end
                  end
               end
            end

            default: begin
               state  <= S_INIT;
               cnt    <= CELL_LAST;
               busy_q <= 1'b1;
            end
         endcase

         // Newline from LF or from a printable in the last column. On the
         // bottom row the screen scrolls: the old top physical row becomes
         // the new bottom row and is blanked.
         if (nl_req) begin
            if (cur_row < ROW_LAST) begin
               cur_row <= cur_row + 5'd1;
            end else begin
               top      <= (top == ROW_LAST) ? 5'd0 : top + 5'd1;
               clr_base <= cell_addr(top, 7'd0);
               cnt      <= COL_LAST_A;
               busy_q   <= 1'b1;
               state    <= S_CLR_ROW;
            end
         end
      end
   end

   // Read-first: a write to the same cell in this cycle lands after the read.
   always_ff @(posedge clk) begin
      if (reset)         rd_char_q <= BLANK;
      else if (rd_valid) rd_char_q <= mem[rd_addr];
      else               rd_char_q <= BLANK;
   end

   assign bus.rd_char  = rd_char_q;
   assign bus.cur_col  = cur_col;
   assign bus.cur_row  = cur_row;
   assign bus.busy     = busy_q;
   assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_vga_text_buffer.sv
module tb_vga_text_buffer;
   localparam int         COLS  = 80;
   localparam int         ROWS  = 30;
   localparam logic [7:0] BLANK = 8'h20;
   localparam int         WAIT_MAX = 6000;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   vga_text_buffer_if bus();

   vga_text_buffer #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference screen, indexed by display row; scrolling shifts rows up.
   logic [7:0] scr [ROWS][COLS];
   int mrow, mcol;

   function automatic void model_clear();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) scr[r][c] = BLANK;
      mrow = 0;
      mcol = 0;
   endfunction

   function automatic void model_newline();
      if (mrow < ROWS - 1) begin
         mrow++;
      end else begin
         for (int r = 0; r < ROWS - 1; r++) scr[r] = scr[r + 1];
         for (int c = 0; c < COLS; c++) scr[ROWS - 1][c] = BLANK;
      end
   endfunction

   function automatic void model_apply(input logic [7:0] b);
      if (b >= 8'h20 && b <= 8'h7E) begin
         scr[mrow][mcol] = b;
         if (mcol == COLS - 1) begin
            mcol = 0;
            model_newline();
         end else begin
            mcol++;
         end
      end else if (b == 8'h0D) begin
         mcol = 0;
      end else if (b == 8'h0A) begin
         model_newline();
      end else if (b == 8'h08) begin
         if (mcol > 0) begin
            mcol--;
            scr[mrow][mcol] = BLANK;
         end
      end
   endfunction

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (bus.busy === 1'b1 && n < WAIT_MAX) begin
         n++;
         @(negedge clk);
      end
      if (n >= WAIT_MAX) begin
         tests_run++;
         tests_failed++;
         $display("FAIL %s: busy still high after %0d cycles", name, n);
      end
   endtask

   // One-cycle strobe; returns the number of cycles busy stayed high after
   // the byte was taken (non-zero only for a scroll or a busy DUT).
   task automatic send_byte(input logic [7:0] b, output int busy_cycles);
      int n;
      @(negedge clk);
      bus.data     = b;
      bus.write_en = 1'b1;
      @(negedge clk);
      bus.write_en = 1'b0;
      @(negedge clk);
      n = 0;
      while (bus.busy === 1'b1 && n < WAIT_MAX) begin
         n++;
         @(negedge clk);
      end
      busy_cycles = n;
      if (n >= WAIT_MAX) begin
         tests_run++;
         tests_failed++;
         $display("FAIL send_byte: busy stuck high, byte %h", b);
      end
      repeat (2) @(negedge clk);
      wait_idle("send_settle");
      model_apply(b);
   endtask

   task automatic read_cell(input int r, input int c, output logic [7:0] v);
      @(negedge clk);
      bus.rd_row = 5'(r);
      bus.rd_col = 7'(c);
      @(negedge clk);
      v = bus.rd_char;
   endtask

   task automatic scan_screen(output int bad, output int fr, output int fc, output logic [7:0] fa);
      logic [7:0] v;
      bad = 0; fr = 0; fc = 0; fa = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            read_cell(r, c, v);
            if (v !== scr[r][c]) begin
               if (bad == 0) begin
                  fr = r; fc = c; fa = v;
               end
               bad++;
            end
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset        = 1'b1;
      bus.write_en = 1'b0;
      bus.rd_row   = '0;
      bus.rd_col   = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      wait_idle("reset_init");
      model_clear();
   endtask

   task automatic test_reset();
      int n, bad, fr, fc;
      logic [7:0] fa;
      bus.write_en = 1'b0;
      bus.data     = '0;
      bus.rd_row   = '0;
      bus.rd_col   = '0;
      reset        = 1'b1;
      repeat (3) @(negedge clk);
      tests_run++;
      if (bus.busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_busy: got %b want 1", bus.busy);
      end
      tests_run++;
      if (bus.cur_col !== 7'd0 || bus.cur_row !== 5'd0) begin
         tests_failed++;
         $display("FAIL reset_cursor: got (%0d,%0d) want (0,0)", bus.cur_row, bus.cur_col);
      end
      tests_run++;
      if (bus.overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_overflow: got %b want 0", bus.overflow);
      end
      tests_run++;
      if (bus.rd_char !== BLANK) begin
         tests_failed++;
         $display("FAIL reset_rd_char: got %h want %h", bus.rd_char, BLANK);
      end
      // Interrupt INIT part way; the restart must take the full count again.
      reset = 1'b0;
      repeat (500) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      n = 0;
      while (bus.busy === 1'b1 && n < 3000) begin
         n++;
         @(negedge clk);
      end
      tests_run++;
      if (n != ROWS * COLS) begin
         tests_failed++;
         $display("FAIL init_cycles: busy high %0d cycles want %0d", n, ROWS * COLS);
      end
      model_clear();
      scan_screen(bad, fr, fc, fa);
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL init_screen: %0d cells differ, (%0d,%0d) got %h want %h",
                  bad, fr, fc, fa, scr[fr][fc]);
      end
   endtask

   task automatic test_ab();
      int bc;
      logic [7:0] v;
      do_reset();
      send_byte(8'h41, bc);
      send_byte(8'h42, bc);
      read_cell(0, 0, v);
      tests_run++;
      if (v !== 8'h41) begin
         tests_failed++;
         $display("FAIL ab_cell00: got %h want 41", v);
      end
      read_cell(0, 1, v);
      tests_run++;
      if (v !== 8'h42) begin
         tests_failed++;
         $display("FAIL ab_cell01: got %h want 42", v);
      end
      tests_run++;
      if (bus.cur_col !== 7'd2 || bus.cur_row !== 5'd0) begin
         tests_failed++;
         $display("FAIL ab_cursor: got (%0d,%0d) want (0,2)", bus.cur_row, bus.cur_col);
      end
   endtask

   task automatic test_wrap();
      int bc, bad, fr, fc;
      logic [7:0] fa;
      do_reset();
      for (int i = 0; i < COLS; i++) send_byte(8'h58, bc);
      tests_run++;
      if (bus.cur_col !== 7'd0 || bus.cur_row !== 5'd1) begin
         tests_failed++;
         $display("FAIL wrap_cursor: got (%0d,%0d) want (1,0)", bus.cur_row, bus.cur_col);
      end
      scan_screen(bad, fr, fc, fa);
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL wrap_screen: %0d cells differ, (%0d,%0d) got %h want %h",
                  bad, fr, fc, fa, scr[fr][fc]);
      end
   endtask

   task automatic test_scroll();
      int bc, bad, fr, fc;
      logic [7:0] fa, v;
      do_reset();
      send_byte(8'h4D, bc);           // 'M' at (0,0)
      send_byte(8'h0A, bc);           // to (1,1)
      send_byte(8'h4F, bc);           // 'O' at (1,1)
      send_byte(8'h0D, bc);           // to (1,0)
      for (int i = 0; i < ROWS - 1; i++) send_byte(8'h0A, bc);
      tests_run++;
      if (bc != COLS) begin
         tests_failed++;
         $display("FAIL scroll_busy: busy high %0d cycles want %0d", bc, COLS);
      end
      send_byte(8'h5A, bc);
      tests_run++;
      if (bus.cur_row !== 5'(ROWS - 1) || bus.cur_col !== 7'd1) begin
         tests_failed++;
         $display("FAIL scroll_cursor: got (%0d,%0d) want (%0d,1)", bus.cur_row, bus.cur_col, ROWS - 1);
      end
      read_cell(0, 1, v);
      tests_run++;
      if (v !== 8'h4F) begin
         tests_failed++;
         $display("FAIL scroll_row0: got %h want 4f", v);
      end
      read_cell(ROWS - 1, 0, v);
      tests_run++;
      if (v !== 8'h5A) begin
         tests_failed++;
         $display("FAIL scroll_bottom: got %h want 5a", v);
      end
      scan_screen(bad, fr, fc, fa);
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL scroll_screen: %0d cells differ, (%0d,%0d) got %h want %h",
                  bad, fr, fc, fa, scr[fr][fc]);
      end
   endtask

   task automatic test_backspace();
      int bc, bad, fr, fc;
      logic [7:0] fa, v;
      do_reset();
      send_byte(8'h51, bc);
      send_byte(8'h08, bc);
      send_byte(8'h08, bc);
      read_cell(0, 0, v);
      tests_run++;
      if (v !== BLANK) begin
         tests_failed++;
         $display("FAIL bs_cell00: got %h want %h", v, BLANK);
      end
      tests_run++;
      if (bus.cur_col !== 7'd0 || bus.cur_row !== 5'd0) begin
         tests_failed++;
         $display("FAIL bs_cursor: got (%0d,%0d) want (0,0)", bus.cur_row, bus.cur_col);
      end
      // BS at column 0 of a lower row must not wrap back.
      send_byte(8'h61, bc);
      send_byte(8'h62, bc);
      send_byte(8'h0A, bc);
      send_byte(8'h0D, bc);
      send_byte(8'h08, bc);
      tests_run++;
      if (bus.cur_col !== 7'd0 || bus.cur_row !== 5'd1) begin
         tests_failed++;
         $display("FAIL bs_nowrap: got (%0d,%0d) want (1,0)", bus.cur_row, bus.cur_col);
      end
      send_byte(8'h07, bc);
      tests_run++;
      if (bus.cur_col !== 7'(mcol) || bus.cur_row !== 5'(mrow)) begin
         tests_failed++;
         $display("FAIL bell_cursor: got (%0d,%0d) want (%0d,%0d)", bus.cur_row, bus.cur_col, mrow, mcol);
      end
      scan_screen(bad, fr, fc, fa);
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL bs_screen: %0d cells differ, (%0d,%0d) got %h want %h",
                  bad, fr, fc, fa, scr[fr][fc]);
      end
   endtask

   task automatic test_random();
      int bc, bad, fr, fc, sel;
      logic [7:0] fa, b, v;
      do_reset();
      for (int i = 0; i < 500; i++) begin
         sel = $urandom_range(0, 99);
         if (sel < 70)      b = 8'($urandom_range(8'h20, 8'h7E));
         else if (sel < 80) b = 8'h0A;
         else if (sel < 85) b = 8'h0D;
         else if (sel < 93) b = 8'h08;
         else begin
            b = 8'($urandom_range(0, 255));
            if ((b >= 8'h20 && b <= 8'h7E) || b == 8'h08 || b == 8'h0A || b == 8'h0D) b = 8'h07;
         end
         send_byte(b, bc);
         if (i % 100 == 99) begin
            tests_run++;
            if (bus.cur_col !== 7'(mcol) || bus.cur_row !== 5'(mrow)) begin
               tests_failed++;
               $display("FAIL rand_cursor: byte %0d got (%0d,%0d) want (%0d,%0d)",
                        i, bus.cur_row, bus.cur_col, mrow, mcol);
            end
         end
      end
      scan_screen(bad, fr, fc, fa);
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL rand_screen: %0d cells differ, (%0d,%0d) got %h want %h",
                  bad, fr, fc, fa, scr[fr][fc]);
      end
      read_cell(0, COLS, v);
      tests_run++;
      if (v !== BLANK) begin
         tests_failed++;
         $display("FAIL oob_col: got %h want %h", v, BLANK);
      end
      read_cell(ROWS, 0, v);
      tests_run++;
      if (v !== BLANK) begin
         tests_failed++;
         $display("FAIL oob_row: got %h want %h", v, BLANK);
      end
      read_cell(31, 127, v);
      tests_run++;
      if (v !== BLANK) begin
         tests_failed++;
         $display("FAIL oob_both: got %h want %h", v, BLANK);
      end
   endtask

   task automatic test_overflow();
      int bc, bad, fr, fc;
      logic [7:0] fa, v;
      do_reset();
      for (int i = 0; i < ROWS - 1; i++) send_byte(8'h0A, bc);
      tests_run++;
      if (bus.overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL ovf_pre: got %b want 0", bus.overflow);
      end
      // LF from the bottom row starts a scroll; two more strobes land in CLR_ROW.
      @(negedge clk);
      bus.data     = 8'h0A;
      bus.write_en = 1'b1;
      @(negedge clk);
      bus.write_en = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovf_clr_busy: got %b want 1", bus.busy);
      end
      bus.data     = 8'h4B;
      bus.write_en = 1'b1;
      @(negedge clk);
      bus.write_en = 1'b0;
      @(negedge clk);
      bus.data     = 8'h4C;
      bus.write_en = 1'b1;
      @(negedge clk);
      bus.write_en = 1'b0;
      wait_idle("ovf_clr");
      repeat (3) @(negedge clk);
      model_apply(8'h0A);
      model_apply(8'h4B);
      tests_run++;
      if (bus.overflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovf_set: got %b want 1", bus.overflow);
      end
      tests_run++;
      if (bus.cur_col !== 7'd1 || bus.cur_row !== 5'(ROWS - 1)) begin
         tests_failed++;
         $display("FAIL ovf_cursor: got (%0d,%0d) want (%0d,1)", bus.cur_row, bus.cur_col, ROWS - 1);
      end
      read_cell(ROWS - 1, 0, v);
      tests_run++;
      if (v !== 8'h4B) begin
         tests_failed++;
         $display("FAIL ovf_kept: got %h want 4b", v);
      end
      // Held strobe: a single character regardless of duration.
      @(negedge clk);
      bus.data     = 8'h57;
      bus.write_en = 1'b1;
      repeat (1000) @(negedge clk);
      bus.write_en = 1'b0;
      repeat (3) @(negedge clk);
      model_apply(8'h57);
      tests_run++;
      if (bus.cur_col !== 7'd2) begin
         tests_failed++;
         $display("FAIL held_cursor: got %0d want 2", bus.cur_col);
      end
      tests_run++;
      if (bus.overflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovf_sticky: got %b want 1", bus.overflow);
      end
      scan_screen(bad, fr, fc, fa);
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL ovf_screen: %0d cells differ, (%0d,%0d) got %h want %h",
                  bad, fr, fc, fa, scr[fr][fc]);
      end
      do_reset();
      tests_run++;
      if (bus.overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL ovf_cleared: got %b want 0", bus.overflow);
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.write_en = 1'b0;
      bus.data     = '0;
      bus.rd_row   = '0;
      bus.rd_col   = '0;
      test_reset();
      test_ab();
      test_wrap();
      test_scroll();
      test_backspace();
      test_random();
      test_overflow();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
